// File: rtl/mem_access_master_if.sv
// Shared definitions for the load/store initiator and the memory array port.
//  - mem_access_pkg : access size encodings used on the request and array ports
//  - mem_array_if   : combinational-read / clocked-write memory array port
// The access master connects through the 'slave' modport; the array model or
// macro connects through the 'array' modport.

package mem_access_pkg;

    localparam logic [1:0] MEM_ACCESS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_ACCESS_SIZE_WORD = 2'd2;

endpackage

interface mem_array_if;

    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic [31:0] rd_data;
    logic        wr_enable;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;

    // Initiator view: drives addresses and write data, receives read data.
    modport slave (
        output rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
        input  rd_data
    );

    // Array view: returns read data combinationally, commits writes on the clock edge.
    modport array (
        input  rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data,
        output rd_data
    );

endinterface

// File: rtl/mem_access_master.sv
// mem_access_master
//  Initiator side of mem_array_if. Takes one load/store request at a time,
//  range-checks it against [START_ADDR, START_ADDR+MEM_SIZE), drives the array
//  port for one cycle and returns an extended load value or a fault.
//  Flow: IDLE -> ACCESS -> RESP -> IDLE (faults go IDLE -> RESP directly).
//  Optional feature macro: MEM_ACCESS_MISALIGNED_SPLIT_EN
//   defined   : misaligned HALF/WORD run as 2/4 ascending BYTE accesses in SPLIT
//   undefined : misaligned HALF/WORD fault; SPLIT is not built

module mem_access_master
    import mem_access_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0001_0000,
    parameter int unsigned MEM_SIZE   = 64 * 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    mem_array_if.slave  memif
);

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_SPLIT  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;
`endif

    // One past the last legal byte, kept 33 bits wide so it cannot wrap.
    localparam logic [32:0] WINDOW_END = {1'b0, START_ADDR} + 33'(MEM_SIZE);

    // Extend a loaded value according to the requested size and signedness.
    function automatic logic [31:0] extend_load(
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic        sign_en
    );
        logic [31:0] result;
        case (size)
            MEM_ACCESS_SIZE_BYTE: result = {{24{sign_en & data[7]}},  data[7:0]};
            MEM_ACCESS_SIZE_HALF: result = {{16{sign_en & data[15]}}, data[15:0]};
            default:              result = data;
        endcase
        return result;
    endfunction

    state_e      r_state;
    state_e      w_next_state;

    // Latched request and response.
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_fault;
    logic [31:0] r_rdata;

    // Registered array-port drive, held stable between accesses.
    logic [31:0] r_mem_addr;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_wdata;

    // Request decode.
    logic        w_accept;
    logic        w_wr_enable;
    logic [2:0]  w_nbytes;
    logic        w_bad_size;
    logic [32:0] w_last_byte;
    logic        w_out_of_window;
    logic        w_misaligned;
    logic        w_fault;
    logic [31:0] w_phys_addr;

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    logic [31:0] r_wdata;
    logic [1:0]  r_cnt;
    logic [1:0]  r_last;
    logic [31:0] r_asm;
    logic [1:0]  w_cnt_inc;
    logic [31:0] w_wdata_shift;
    logic [31:0] w_asm_next;
`endif

    assign w_accept    = req_valid_i && req_ready_o;
    assign w_phys_addr = req_addr_i - START_ADDR;
    assign w_bad_size  = (req_size_i == 2'b11);

    // Byte count of the requested access; reserved encoding is sized as a word.
    always_comb begin
        case (req_size_i)
            MEM_ACCESS_SIZE_BYTE: w_nbytes = 3'd1;
            MEM_ACCESS_SIZE_HALF: w_nbytes = 3'd2;
            default:              w_nbytes = 3'd4;
        endcase
    end

    assign w_last_byte     = {1'b0, req_addr_i} + {30'b0, w_nbytes} - 33'd1;
    assign w_out_of_window = (req_addr_i < START_ADDR) || (w_last_byte >= WINDOW_END);
    assign w_misaligned    = ((req_size_i == MEM_ACCESS_SIZE_HALF) && req_addr_i[0]) ||
                             ((req_size_i == MEM_ACCESS_SIZE_WORD) && (req_addr_i[1:0] != 2'b00));

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    // Misaligned accesses are split, so only the window and the size encoding fault.
    assign w_fault = w_out_of_window || w_bad_size;
`else
    // Misaligned accesses cannot be expressed on the array port and are rejected.
    assign w_fault = w_out_of_window || w_bad_size || w_misaligned;
`endif

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/strobe decode from the current state.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        w_next_state = r_state;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        w_wr_enable  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (w_fault) begin
                        w_next_state = ST_RESP;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                    end else if (w_misaligned) begin
                        w_next_state = ST_SPLIT;
`endif
                    end else begin
                        w_next_state = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                w_wr_enable  = r_we;
                w_next_state = ST_RESP;
            end
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            ST_SPLIT: begin
                w_wr_enable = r_we;
                if (r_cnt == r_last) begin
                    w_next_state = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    assign w_cnt_inc     = r_cnt + 2'd1;
    assign w_wdata_shift = r_wdata >> {w_cnt_inc, 3'b000};

    // Place the byte read this cycle into its lane of the assembled load value.
    always_comb begin
        w_asm_next                       = r_asm;
        w_asm_next[{r_cnt, 3'b000} +: 8] = memif.rd_data[7:0];
    end
`endif

    // Request latch, array-port drive and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we        <= 1'b0;
            r_size      <= MEM_ACCESS_SIZE_WORD;
            r_signed    <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_size  <= MEM_ACCESS_SIZE_WORD;
            r_mem_wdata <= '0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            r_wdata     <= '0;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_asm       <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_we     <= req_we_i;
                r_size   <= req_size_i;
                r_signed <= req_signed_i;
                r_fault  <= w_fault;
                r_rdata  <= '0;
                // A faulted request leaves the array port untouched.
                if (!w_fault) begin
                    r_mem_addr <= w_phys_addr;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                    if (w_misaligned) begin
                        r_mem_size  <= MEM_ACCESS_SIZE_BYTE;
                        r_mem_wdata <= {24'b0, req_wdata_i[7:0]};
                        r_wdata     <= req_wdata_i;
                        r_cnt       <= 2'd0;
                        r_last      <= 2'(w_nbytes - 3'd1);
                        r_asm       <= '0;
                    end else begin
                        r_mem_size  <= req_size_i;
                        r_mem_wdata <= req_wdata_i;
                    end
`else
                    r_mem_size  <= req_size_i;
                    r_mem_wdata <= req_wdata_i;
`endif
                end
            end

            if ((r_state == ST_ACCESS) && !r_we) begin
                r_rdata <= extend_load(memif.rd_data, r_size, r_signed);
            end

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            if (r_state == ST_SPLIT) begin
                r_asm <= w_asm_next;
                if (r_cnt == r_last) begin
                    if (!r_we) begin
                        r_rdata <= extend_load(w_asm_next, r_size, r_signed);
                    end
                end else begin
                    r_cnt       <= w_cnt_inc;
                    r_mem_addr  <= r_mem_addr + 32'd1;
                    r_mem_wdata <= {24'b0, w_wdata_shift[7:0]};
                end
            end
`endif
        end
    end

    assign rsp_rdata_o     = r_rdata;
    assign rsp_fault_o     = r_fault;

    assign memif.rd_addr   = r_mem_addr;
    assign memif.rd_size   = r_mem_size;
    assign memif.wr_addr   = r_mem_addr;
    assign memif.wr_size   = r_mem_size;
    assign memif.wr_data   = r_mem_wdata;
    assign memif.wr_enable = w_wr_enable;

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master: directed loads/stores against a byte-array
// memory model. Stimulus pushes the expected response into a scoreboard queue;
// a monitor pops and compares each response handshake (data, fault, latency,
// number of write strobes) and checks response stability under backpressure.

module tb_mem_access_master;
    import mem_access_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wrs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_fault_o;

    mem_array_if memif();

    exp_t        sb[$];
    logic [31:0] wr_log[$];
    logic [7:0]  mem [0:65535];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;

    mem_access_master dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_fault_o  (rsp_fault_o),
        .memif        (memif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int size_bytes(input logic [1:0] size);
        if (size == MEM_ACCESS_SIZE_BYTE) return 1;
        if (size == MEM_ACCESS_SIZE_HALF) return 2;
        return 4;
    endfunction

    // Memory model: combinational little-endian read, write on the clock edge.
    always_comb begin
        memif.rd_data = {mem[16'(memif.rd_addr + 32'd3)], mem[16'(memif.rd_addr + 32'd2)],
                         mem[16'(memif.rd_addr + 32'd1)], mem[16'(memif.rd_addr)]};
    end

    always @(posedge clk) begin
        if (memif.wr_enable) begin
            wr_log.push_back(memif.wr_addr);
            for (int k = 0; k < size_bytes(memif.wr_size); k++) begin
                mem[16'(memif.wr_addr + 32'(k))] <= memif.wr_data[8*k +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Monitor: tracks accept cycle, write strobes and response timing; pops
    // the scoreboard on every response handshake.
    initial begin : monitor
        int          acc_cyc    = 0;
        int          rsp_start  = 0;
        int          wr_cnt     = 0;
        logic        prev_valid = 1'b0;
        logic [31:0] hold       = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (req_valid_i && req_ready_o) begin
                acc_cyc = cyc;
                wr_cnt  = 0;
            end
            if (memif.wr_enable) wr_cnt++;
            if (rsp_valid_o && !prev_valid) begin
                rsp_start = cyc;
                hold      = rsp_rdata_o;
            end
            if (rsp_valid_o && prev_valid && !rsp_ready_i) begin
                check("hold_rdata", rsp_rdata_o, hold);
                check("hold_req_ready", 32'(req_ready_o), 32'd0);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    check("rsp_without_expectation", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_rdata"}, rsp_rdata_o, e.rdata);
                    check({e.name, "_fault"}, 32'(rsp_fault_o), 32'(e.fault));
                    check({e.name, "_latency"}, 32'(rsp_start - acc_cyc), 32'(e.lat));
                    check({e.name, "_wr_strobes"}, 32'(wr_cnt), 32'(e.wrs));
                end
            end
            prev_valid = rsp_valid_o;
        end
    end

    // Push the expectation, present the request and wait for it to be accepted.
    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                         input logic [31:0] e_rdata, input logic e_fault, input int e_lat,
                         input int e_wrs, output int acc);
        exp_t e;
        e.name  = name;
        e.rdata = e_rdata;
        e.fault = e_fault;
        e.lat   = e_lat;
        e.wrs   = e_wrs;
        sb.push_back(e);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_size_i   = size;
        req_signed_i = sgn;
        req_wdata_i  = wdata;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check({name, "_accepted"}, 32'(acc >= 0), 32'd1);
        if (acc >= 0) @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic ld(input string name, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] e_rdata, input logic e_fault,
                      input int e_lat);
        int acc;
        issue(name, 1'b0, addr, size, sgn, 32'h0, e_rdata, e_fault, e_lat, 0, acc);
        wait_idle(name);
    endtask

    task automatic st(input string name, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input logic e_fault, input int e_lat,
                      input int e_wrs);
        int acc;
        issue(name, 1'b1, addr, size, 1'b0, wdata, 32'h0, e_fault, e_lat, e_wrs, acc);
        wait_idle(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a0, a1, a2;
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_size_i   = MEM_ACCESS_SIZE_WORD;
        req_signed_i = 1'b0;
        req_wdata_i  = '0;
        rsp_ready_i  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        mem[3] <= 8'h80;
        mem[4] <= 8'h01;
        mem[5] <= 8'h80;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault_o), 32'd0);
        check("rst_wr_enable", 32'(memif.wr_enable), 32'd0);
        check("rst_rd_addr", memif.rd_addr, 32'h0);
        check("rst_rd_size", 32'(memif.rd_size), 32'(MEM_ACCESS_SIZE_WORD));
        check("rst_wr_data", memif.wr_data, 32'h0);
        rst_n = 1'b1;

        // Aligned word store then load back
        wr_log.delete();
        st("t1_st", 32'h0001_0010, MEM_ACCESS_SIZE_WORD, 32'hDEAD_BEEF, 1'b0, 2, 1);
        check("t1_wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) check("t1_wr_addr", wr_log[0], 32'h0000_0010);
        ld("t1_ld", 32'h0001_0010, MEM_ACCESS_SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);

        // Sign / zero extension
        ld("t2_byte_s", 32'h0001_0003, MEM_ACCESS_SIZE_BYTE, 1'b1, 32'hFFFF_FF80, 1'b0, 2);
        ld("t2_byte_u", 32'h0001_0003, MEM_ACCESS_SIZE_BYTE, 1'b0, 32'h0000_0080, 1'b0, 2);
        ld("t2_half_s", 32'h0001_0004, MEM_ACCESS_SIZE_HALF, 1'b1, 32'hFFFF_8001, 1'b0, 2);
        ld("t2_half_u", 32'h0001_0004, MEM_ACCESS_SIZE_HALF, 1'b0, 32'h0000_8001, 1'b0, 2);

        // Window boundaries
        ld("t3_below",  32'h0000_FFFC, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0, 1'b1, 1);
        ld("t3_above",  32'h0002_0000, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0, 1'b1, 1);
        ld("t3_top",    32'h0001_FFFC, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0, 1'b0, 2);
        ld("t3_wrap",   32'hFFFF_FFFF, MEM_ACCESS_SIZE_BYTE, 1'b0, 32'h0, 1'b1, 1);
        ld("t3_half_top", 32'h0001_FFFE, MEM_ACCESS_SIZE_HALF, 1'b0, 32'h0, 1'b0, 2);
        st("t3_st_below", 32'h0000_FFFC, MEM_ACCESS_SIZE_WORD, 32'h1111_1111, 1'b1, 1, 0);

        // Misaligned accesses
        wr_log.delete();
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        st("t4_st_mis", 32'h0001_0001, MEM_ACCESS_SIZE_WORD, 32'hDEAD_BEEF, 1'b0, 5, 4);
        check("t4_wr_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            for (int k = 0; k < 4; k++) check("t4_wr_addr", wr_log[k], 32'(k + 1));
        end
        ld("t4_ld_mis", 32'h0001_0001, MEM_ACCESS_SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0, 5);
        ld("t4_half_mis", 32'h0001_0003, MEM_ACCESS_SIZE_HALF, 1'b1, 32'hFFFF_DEAD, 1'b0, 3);
`else
        st("t4_st_mis", 32'h0001_0001, MEM_ACCESS_SIZE_WORD, 32'hDEAD_BEEF, 1'b1, 1, 0);
        check("t4_wr_count", 32'(wr_log.size()), 32'd0);
        ld("t4_half_mis", 32'h0001_0003, MEM_ACCESS_SIZE_HALF, 1'b1, 32'h0, 1'b1, 1);
`endif

        // Reset during the ACCESS cycle of a store
        issue("t5_st_abort", 1'b1, 32'h0001_0020, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h1234_5678,
              32'h0, 1'b0, 2, 1, a0);
        check("t5_wr_enable_before", 32'(memif.wr_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_wr_enable_async", 32'(memif.wr_enable), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("t5_req_ready", 32'(req_ready_o), 32'd1);
        sb.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_req_ready_after", 32'(req_ready_o), 32'd1);
        ld("t5_ld_unwritten", 32'h0001_0020, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0, 1'b0, 2);

        // Response backpressure for five cycles
        rsp_ready_i = 1'b0;
        issue("t6_hold", 1'b0, 32'h0001_0010, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0,
              32'hDEAD_BEEF, 1'b0, 2, 0, a0);
        for (int i = 0; i < 20 && !rsp_valid_o; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        rsp_ready_i = 1'b1;
        wait_idle("t6_hold");

        // Back-to-back requests: one accept every three cycles
        issue("t6_b2b_0", 1'b0, 32'h0001_0010, MEM_ACCESS_SIZE_WORD, 1'b0, 32'h0,
              32'hDEAD_BEEF, 1'b0, 2, 0, a0);
        issue("t6_b2b_1", 1'b0, 32'h0001_0005, MEM_ACCESS_SIZE_BYTE, 1'b1, 32'h0,
              32'hFFFF_FF80, 1'b0, 2, 0, a1);
        issue("t6_b2b_2", 1'b0, 32'h0001_0005, MEM_ACCESS_SIZE_BYTE, 1'b0, 32'h0,
              32'h0000_0080, 1'b0, 2, 0, a2);
        wait_idle("t6_b2b");
        check("t6_gap_01", 32'(a1 - a0), 32'd3);
        check("t6_gap_12", 32'(a2 - a1), 32'd3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
